// File: rtl/mem_request_arbiter.sv
// Multi-channel memory request arbiter: picks one CPU-side channel (fixed priority
// or round-robin), runs a single bus transaction and routes done/err/rdata back.
module mem_request_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 2,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
  input  logic [NUM_CH*(DATA_W/8)-1:0] ch_be,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_done,
  output logic [NUM_CH-1:0]            ch_err,
  output logic [DATA_W-1:0]            ch_rdata,
  input  logic                         bus_busy,
  input  logic                         bus_ack,
  input  logic [DATA_W-1:0]            bus_rdata,
  output logic                         bus_req,
  output logic                         bus_we,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [DATA_W-1:0]            bus_wdata,
  output logic [(DATA_W/8)-1:0]        bus_be,
  output logic [2:0]                   state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_ACK  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t cur, nxt;

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   win;
  logic [CH_W-1:0]   idx;
  logic              any_req;
  logic [TMR_W-1:0]  timer;
  logic              tmo;
  logic [DATA_W-1:0] rdata_cap;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_be;
  logic              win_we;

  assign any_req = |ch_req;
  assign state   = cur;
  assign bus_req = (cur == S_ACK);
  assign tmo     = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1));

  // Descending scan so the candidate closest to the start point is written last and wins.
  always_comb begin
    win = '0;
    idx = '0;
    if (RR_EN != 0) begin
      for (int i = NUM_CH; i >= 1; i--) begin
        idx = CH_W'((int'(ptr) + i) % NUM_CH);
        if (ch_req[idx]) win = idx;
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        idx = CH_W'(i);
        if (ch_req[idx]) win = idx;
      end
    end
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_be    = '0;
    win_we    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == win) begin
        win_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        win_wdata = ch_wdata[i*DATA_W +: DATA_W];
        win_be    = ch_be[i*BE_W +: BE_W];
        win_we    = ch_we[i];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cur <= S_IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE: if (any_req) nxt = S_REQ;
      S_REQ:  nxt = bus_busy ? S_WAIT : S_ACK;
      S_WAIT: if (!bus_busy) nxt = S_REQ;
      S_ACK: begin
        if (bus_ack)  nxt = S_DONE;
        else if (tmo) nxt = S_IDLE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Pulses are registered, so done/err appear in the cycle after leaving DONE/ACK.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr       <= CH_W'(NUM_CH - 1);
      sel       <= '0;
      timer     <= '0;
      rdata_cap <= '0;
      ch_gnt    <= '0;
      ch_done   <= '0;
      ch_err    <= '0;
      ch_rdata  <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      ch_gnt  <= '0;
      ch_done <= '0;
      ch_err  <= '0;
      if (cur != S_ACK) timer <= '0;
      else              timer <= timer + 1'b1;
      case (cur)
        S_IDLE: begin
          if (any_req) begin
            sel       <= win;
            bus_addr  <= win_addr;
            bus_we    <= win_we;
            bus_wdata <= win_we ? win_wdata : '0;
            bus_be    <= win_we ? win_be : '1;
            ch_gnt    <= NUM_CH'(1) << win;
          end
        end
        S_ACK: begin
          if (bus_ack) begin
            if (!bus_we) rdata_cap <= bus_rdata;
          end else if (tmo) begin
            ch_err <= NUM_CH'(1) << sel;
            ptr    <= sel;
          end
        end
        S_DONE: begin
          ch_done <= NUM_CH'(1) << sel;
          if (!bus_we) ch_rdata <= rdata_cap;
          ptr <= sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: round-robin and fixed-priority instances share
// stimulus; completions are scoreboarded against expectations queued at request time.
module tb_mem_request_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [1:0]  ch_req = '0;
  logic [1:0]  ch_we = '0;
  logic [63:0] ch_addr = '0;
  logic [63:0] ch_wdata = '0;
  logic [7:0]  ch_be = '0;
  logic        bus_busy = 1'b0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic [1:0]  gnt_rr, done_rr, err_rr, gnt_fp, done_fp, err_fp;
  logic [31:0] rdata_rr, rdata_fp, bwdata_rr, bwdata_fp, baddr_rr, baddr_fp;
  logic        breq_rr, breq_fp, bwe_rr, bwe_fp;
  logic [3:0]  bbe_rr, bbe_fp;
  logic [2:0]  st_rr, st_fp;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        err;
    int          ch;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb[$];
  sb_t e;
  logic [31:0] last_rd = '0;
  int cnt;
  int w;

  always #5 clk = ~clk;

  mem_request_arbiter #(.ADDR_W(32), .DATA_W(32), .NUM_CH(2), .RR_EN(1), .TIMEOUT(4)) u_rr (
    .clk(clk), .nrst(nrst), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_be(ch_be), .ch_gnt(gnt_rr), .ch_done(done_rr), .ch_err(err_rr),
    .ch_rdata(rdata_rr), .bus_busy(bus_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(breq_rr), .bus_we(bwe_rr), .bus_addr(baddr_rr), .bus_wdata(bwdata_rr),
    .bus_be(bbe_rr), .state(st_rr));

  mem_request_arbiter #(.ADDR_W(32), .DATA_W(32), .NUM_CH(2), .RR_EN(0), .TIMEOUT(4)) u_fp (
    .clk(clk), .nrst(nrst), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_be(ch_be), .ch_gnt(gnt_fp), .ch_done(done_fp), .ch_err(err_fp),
    .ch_rdata(rdata_fp), .bus_busy(bus_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(breq_fp), .bus_we(bwe_fp), .bus_addr(baddr_fp), .bus_wdata(bwdata_fp),
    .bus_be(bbe_fp), .state(st_fp));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ch(input int c, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    ch_we[c] = we;
    ch_addr[c*32 +: 32] = addr;
    ch_wdata[c*32 +: 32] = wdata;
    ch_be[c*4 +: 4] = be;
  endtask

  // Scoreboard: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done_rr != 2'b00 || err_rr != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {done_rr, err_rr}, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_done", done_rr, e.err ? 0 : (1 << e.ch));
        chk("sb_err", err_rr, e.err ? (1 << e.ch) : 0);
        chk("sb_rdata", rdata_rr, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_state", st_rr, 0);
    chk("rst_bus_req", breq_rr, 0);
    chk("rst_gnt", gnt_rr, 0);
    chk("rst_rdata", rdata_rr, 0);
    chk("rst_be", bbe_rr, 0);
    step(); step();
    nrst = 1'b1;
    step();

    // Single read on ch1, ack in the first ACK cycle
    drive_ch(1, 1'b0, 32'h100, 32'h0, 4'h0);
    ch_req = 2'b10;
    sb.push_back('{1'b0, 1, 32'hDEADBEEF});
    last_rd = 32'hDEADBEEF;
    step();
    chk("t1_req_state", st_rr, 1);
    chk("t1_gnt", gnt_rr, 2'b10);
    chk("t1_bus_req_req", breq_rr, 0);
    ch_req = 2'b00;
    step();
    chk("t1_ack_state", st_rr, 3);
    chk("t1_gnt_once", gnt_rr, 0);
    chk("t1_bus_req", breq_rr, 1);
    chk("t1_addr", baddr_rr, 32'h100);
    chk("t1_be", bbe_rr, 4'hF);
    chk("t1_wdata", bwdata_rr, 0);
    chk("t1_we", bwe_rr, 0);
    bus_ack = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    step();
    chk("t1_done_state", st_rr, 4);
    chk("t1_bus_req_done", breq_rr, 0);
    bus_ack = 1'b0;
    bus_rdata = '0;
    step();
    chk("t1_idle", st_rr, 0);
    chk("t1_ch_done", done_rr, 2'b10);
    chk("t1_rdata", rdata_rr, 32'hDEADBEEF);

    // Write on ch0 with bus_busy stall for 3 WAIT cycles
    drive_ch(0, 1'b1, 32'h40, 32'h12345678, 4'b0011);
    ch_req = 2'b01;
    bus_busy = 1'b1;
    sb.push_back('{1'b0, 0, last_rd});
    step();
    chk("t2_gnt", gnt_rr, 2'b01);
    ch_req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_wait_state", st_rr, 2);
      chk("t2_wait_bus_req", breq_rr, 0);
      chk("t2_wait_gnt", gnt_rr, 0);
    end
    bus_busy = 1'b0;
    step();
    chk("t2_rereq_state", st_rr, 1);
    chk("t2_no_regnt", gnt_rr, 0);
    step();
    chk("t2_ack_state", st_rr, 3);
    chk("t2_bus_req", breq_rr, 1);
    chk("t2_we", bwe_rr, 1);
    chk("t2_addr", baddr_rr, 32'h40);
    chk("t2_wdata", bwdata_rr, 32'h12345678);
    chk("t2_be", bbe_rr, 4'b0011);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    chk("t2_done", done_rr, 2'b01);
    chk("t2_rdata_kept", rdata_rr, 32'hDEADBEEF);

    // Timeout: no ack, bus_req high exactly TIMEOUT cycles
    drive_ch(1, 1'b0, 32'h200, 32'h0, 4'h0);
    ch_req = 2'b10;
    sb.push_back('{1'b1, 1, last_rd});
    step();
    chk("t3_gnt", gnt_rr, 2'b10);
    ch_req = 2'b00;
    step();
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (breq_rr) cnt++;
      if (err_rr != 2'b00) break;
      step();
    end
    chk("t3_bus_req_cycles", cnt, 4);
    chk("t3_err", err_rr, 2'b10);
    chk("t3_no_done", done_rr, 0);
    chk("t3_idle", st_rr, 0);
    chk("t3_rdata_kept", rdata_rr, 32'hDEADBEEF);
    drive_ch(0, 1'b0, 32'h300, 32'h0, 4'h0);
    ch_req = 2'b01;
    sb.push_back('{1'b0, 0, 32'hCAFEF00D});
    last_rd = 32'hCAFEF00D;
    step();
    chk("t3b_gnt", gnt_rr, 2'b01);
    ch_req = 2'b00;
    step();
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    step();
    bus_ack = 1'b0;
    step();
    chk("t3b_done", done_rr, 2'b01);
    chk("t3b_rdata", rdata_rr, 32'hCAFEF00D);

    // Spurious bus_ack in IDLE and WAIT
    bus_ack = 1'b1;
    step();
    chk("sp_idle_state", st_rr, 0);
    step();
    chk("sp_idle_state2", st_rr, 0);
    chk("sp_idle_done", done_rr, 0);
    bus_ack = 1'b0;
    drive_ch(1, 1'b1, 32'h500, 32'hAA55AA55, 4'hF);
    ch_req = 2'b10;
    bus_busy = 1'b1;
    sb.push_back('{1'b0, 1, last_rd});
    step();
    ch_req = 2'b00;
    step();
    chk("sp_wait_state", st_rr, 2);
    bus_ack = 1'b1;
    step();
    chk("sp_wait_hold", st_rr, 2);
    step();
    chk("sp_wait_hold2", st_rr, 2);
    chk("sp_wait_done", done_rr, 0);
    bus_ack = 1'b0;
    bus_busy = 1'b0;
    step();
    chk("sp_rereq", st_rr, 1);
    step();
    chk("sp_ack", st_rr, 3);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    chk("sp_done", done_rr, 2'b10);

    // Asynchronous reset mid-ACK drops the transaction
    drive_ch(1, 1'b0, 32'h600, 32'h0, 4'h0);
    ch_req = 2'b10;
    step();
    ch_req = 2'b00;
    step();
    chk("rs_ack_state", st_rr, 3);
    #2;
    nrst = 1'b0;
    #1;
    chk("rs_state", st_rr, 0);
    chk("rs_bus_req", breq_rr, 0);
    chk("rs_addr", baddr_rr, 0);
    chk("rs_be", bbe_rr, 0);
    chk("rs_rdata", rdata_rr, 0);
    chk("rs_pulses", {gnt_rr, done_rr, err_rr}, 0);
    last_rd = '0;
    step(); step();
    nrst = 1'b1;
    step();

    // Both channels requesting continuously with immediate acks
    drive_ch(0, 1'b1, 32'h1000, 32'h11111111, 4'hF);
    drive_ch(1, 1'b1, 32'h2000, 32'h22222222, 4'hF);
    bus_ack = 1'b1;
    ch_req = 2'b11;
    for (int k = 0; k < 4; k++) sb.push_back('{1'b0, k % 2, last_rd});
    for (int k = 0; k < 4; k++) begin
      w = 0;
      do begin
        step();
        w++;
      end while (gnt_rr == 2'b00 && w < 20);
      chk("rr_order", gnt_rr, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("fp_order", gnt_fp, 2'b01);
    end
    ch_req = 2'b00;
    for (int k = 0; k < 4; k++) step();
    bus_ack = 1'b0;
    step();
    chk("sb_empty", sb.size(), 0);
    chk("final_idle", st_rr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
